mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage responder for the pipeline's decoded memory requests (mem_read / mem_write from the control decoder, gated by flush).
- Accepts one request at a time, drives a fixed-latency data memory port, stalls the pipeline while the access is outstanding, and returns load data to the MEM/WB path.
- Sits between the EX/MEM pipeline register and the external data memory.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- MEM_LATENCY, 2, number of cycles m_read/m_write are held before the access completes; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  load request from the MEM-stage control bits.
- mem_write  input  1  store request from the MEM-stage control bits.
- flush  input  1  squash: a request presented with flush=1 is ignored.
- addr  input  WORD_SIZE  access address (ALU result).
- wdata  input  WORD_SIZE  store data.
- rdata  output  WORD_SIZE  registered load data, valid while done=1 and held until the next load completes.
- stall  output  1  freeze PC and IF/ID/EX/MEM registers.
- done  output  1  one-cycle pulse: the access completed this cycle.
- m_read  output  1  memory read strobe.
- m_write  output  1  memory write strobe.
- m_addr  output  WORD_SIZE  latched address to memory.
- m_wdata  output  WORD_SIZE  latched store data to memory.
- m_rdata  input  WORD_SIZE  memory read data, valid in the last BUSY cycle.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, rdata=0, m_addr=0, m_wdata=0, m_read=m_write=0, done=0, stall=0.
- States: IDLE, BUSY, DONE.
- Request definition: req = (mem_read | mem_write) & ~flush.
- If mem_read and mem_write are both 1, the request is a write; no read is performed.
- IDLE:
  - If req=1, latch addr, wdata and kind on the clock edge; counter = MEM_LATENCY-1; go to BUSY.
  - stall is combinational: stall = req. The requesting instruction is frozen in the same cycle it appears.
- BUSY:
  - m_read or m_write (per the latched kind) held high.
  - m_addr and m_wdata hold the latched values.
  - stall=1.
  - When counter=0: capture m_rdata into rdata if the kind is read, then go to DONE. Otherwise decrement the counter.
  - Total BUSY cycles = MEM_LATENCY.
- DONE:
  - done=1, stall=0, strobes low. The pipeline advances on this edge.
  - Always return to IDLE. The request still visible on the inputs this cycle belongs to the completed instruction and must not be re-accepted.
- Latency: a request seen in cycle t gives done in cycle t+MEM_LATENCY+1. A back-to-back request is accepted no earlier than the cycle after DONE.
- flush does not abort an access that is already in flight. Inputs are don't-care during BUSY because the latched copies are used.
- rdata is unchanged by writes and by flushed requests.
- Reset asserted mid-BUSY: strobes drop immediately, the access is abandoned, and no done pulse is produced.
- Counter width: 4 bits.

Optional Feature:
- Macro: MEM_WRITE_POST_EN.
- Defined:
  - An accepted write does not stall: stall=0 in the accept cycle and throughout the write's BUSY.
  - done is pulsed in the accept cycle.
  - The write runs in the background.
  - A new request (read or write) arriving while the posted write is in BUSY or DONE raises stall=1 until the state machine returns to IDLE. It is then accepted normally.
  - Reads never post.
- Undefined: writes stall exactly as reads do, per Behaviour.

Test Plan:
- Read, MEM_LATENCY=2: mem_read=1, addr=0x0040, memory returns 0xBEEF → stall high for 3 cycles (IDLE accept + 2 BUSY), m_read high for exactly 2 cycles, done pulse in the 4th cycle, rdata=0xBEEF.
- Write: mem_write=1, addr=0x0010, wdata=0x1234 → m_write high for 2 cycles with m_addr=0x0010 and m_wdata=0x1234; rdata keeps its previous value.
- Flush: mem_read=1, flush=1 → no strobe, stall=0, state stays IDLE; then flush deasserted with the same inputs → access proceeds.
- Back-to-back read then write, with inputs held through DONE → exactly two accesses and two done pulses, and no duplicate read.
- Async reset mid-BUSY → m_read drops without waiting for the clock and no done pulse occurs; a later request completes normally.
- With MEM_WRITE_POST_EN defined: write followed immediately by a read → write accept cycle has stall=0 and done=1; the read stalls until the write finishes, then takes MEM_LATENCY+1 cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: latches one request, drives a fixed-latency data memory, stalls the pipeline.
// Optional build macro MEM_WRITE_POST_EN: accepted stores retire immediately and finish in the background.
module mem_access_unit #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 stall,
    output logic                 done,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_write;
    logic                 r_done;
    logic                 r_m_read;
    logic                 r_m_write;
    logic [WORD_SIZE-1:0] r_m_addr;
    logic [WORD_SIZE-1:0] r_m_wdata;
    logic [WORD_SIZE-1:0] r_rdata;

    logic w_req;
    logic w_is_write;
    logic w_in_idle;
    logic w_in_busy;
    logic w_done_set;

    // Simultaneous read+write requests resolve to a write.
    assign w_req      = (mem_read | mem_write) & ~flush;
    assign w_is_write = mem_write;
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_busy  = (r_state == ST_BUSY);

`ifdef MEM_WRITE_POST_EN
    logic w_posted;

    // A posted write has already retired; inputs seen meanwhile are new requests that must wait.
    assign w_posted   = r_is_write & ~w_in_idle;
    assign stall      = w_in_idle ? (w_req & ~w_is_write)
                                  : (w_posted ? w_req : w_in_busy);
    assign done       = r_done | (w_in_idle & w_req & w_is_write);
    assign w_done_set = ~r_is_write;
`else
    assign stall      = w_in_idle ? w_req : w_in_busy;
    assign done       = r_done;
    assign w_done_set = 1'b1;
`endif

    assign rdata   = r_rdata;
    assign m_read  = r_m_read;
    assign m_write = r_m_write;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

    // Access sequencer; the request held through DONE belongs to the finished access and is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_done     <= 1'b0;
            r_m_read   <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_rdata    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state    <= ST_BUSY;
                        r_cnt      <= CNT_W'(MEM_LATENCY - 1);
                        r_is_write <= w_is_write;
                        r_m_addr   <= addr;
                        r_m_wdata  <= wdata;
                        r_m_read   <= ~w_is_write;
                        r_m_write  <= w_is_write;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        r_done    <= w_done_set;
                        if (!r_is_write) begin
                            r_rdata <= m_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model, a small memory device, directed vectors.
module tb_mem_access_unit;

    localparam int L = 2;
`ifdef MEM_WRITE_POST_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        flush;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        stall;
    logic        done;
    logic        m_read;
    logic        m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    mem_access_unit #(
        .WORD_SIZE  (16),
        .MEM_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .flush    (flush),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .done     (done),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory device contents (driven from DUT strobes) and the model's own copy
    logic [15:0] dmem    [16];
    logic [15:0] exp_mem [16];
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    // transaction model: age counts cycles since acceptance (1..L busy, L+1 completion)
    bit          mdl_active = 1'b0;
    int          mdl_age    = 0;
    bit          mdl_w      = 1'b0;
    logic [15:0] mdl_addr   = 16'h0;
    logic [15:0] mdl_wdata  = 16'h0;
    logic [15:0] mdl_rdata  = 16'h0;

    // running observation totals, differenced by the directed tests
    int   win_stall = 0, win_done = 0, win_rd = 0, win_wr = 0;
    int   s_stall, s_done, s_rd, s_wr;
    logic last_stall, last_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        s_stall = win_stall;
        s_done  = win_done;
        s_rd    = win_rd;
        s_wr    = win_wr;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic fl,
                         input logic [15:0] a, input logic [15:0] d);
        mem_read  = rd;
        mem_write = wr;
        flush     = fl;
        addr      = a;
        wdata     = d;
    endtask

    // One clock cycle: device step, model compare and advance at negedge; return at posedge+1.
    task automatic tick();
        logic req, isw, posted;
        logic e_stall, e_done, e_mr, e_mw;
        @(negedge clk);
        if (m_read) begin
            rd_cnt  = rd_cnt + 1;
            m_rdata = (rd_cnt == L) ? dmem[m_addr[7:4]] : 16'hDEAD;
        end else begin
            rd_cnt  = 0;
            m_rdata = 16'hDEAD;
        end
        if (m_write) begin
            wr_cnt = wr_cnt + 1;
            if (wr_cnt == L) dmem[m_addr[7:4]] = m_wdata;
        end else begin
            wr_cnt = 0;
        end
        last_stall = stall;
        last_done  = done;
        win_stall += int'(stall);
        win_done  += int'(done);
        win_rd    += int'(m_read);
        win_wr    += int'(m_write);

        req    = (mem_read | mem_write) & ~flush;
        isw    = mem_write;
        posted = POST && mdl_active && mdl_w;
        if (reset) begin
            mdl_active = 1'b0;
            mdl_age    = 0;
            mdl_addr   = 16'h0;
            mdl_wdata  = 16'h0;
            mdl_rdata  = 16'h0;
            e_stall = 1'b0; e_done = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
        end else if (!mdl_active) begin
            e_stall = req && !(POST && isw);
            e_done  = POST && req && isw;
            e_mr    = 1'b0;
            e_mw    = 1'b0;
        end else if (mdl_age <= L) begin
            e_stall = posted ? req : 1'b1;
            e_done  = 1'b0;
            e_mr    = !mdl_w;
            e_mw    = mdl_w;
        end else begin
            e_stall = posted ? req : 1'b0;
            e_done  = !posted;
            e_mr    = 1'b0;
            e_mw    = 1'b0;
        end

        chk("cyc_stall",   32'(stall),   32'(e_stall));
        chk("cyc_done",    32'(done),    32'(e_done));
        chk("cyc_m_read",  32'(m_read),  32'(e_mr));
        chk("cyc_m_write", 32'(m_write), 32'(e_mw));
        chk("cyc_m_addr",  32'(m_addr),  32'(mdl_addr));
        chk("cyc_m_wdata", 32'(m_wdata), 32'(mdl_wdata));
        chk("cyc_rdata",   32'(rdata),   32'(mdl_rdata));

        if (!reset) begin
            if (!mdl_active) begin
                if (req) begin
                    mdl_active = 1'b1;
                    mdl_age    = 1;
                    mdl_w      = isw;
                    mdl_addr   = addr;
                    mdl_wdata  = wdata;
                end
            end else begin
                if (mdl_age == L) begin
                    if (mdl_w) exp_mem[mdl_addr[7:4]] = mdl_wdata;
                    else       mdl_rdata = exp_mem[mdl_addr[7:4]];
                end
                mdl_age = mdl_age + 1;
                if (mdl_age > L + 1) mdl_active = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        m_rdata = 16'hDEAD;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 16'h1000 + 16'(i);
            exp_mem[i] = 16'h1000 + 16'(i);
        end
        dmem[4] = 16'hBEEF; exp_mem[4] = 16'hBEEF;
        dmem[5] = 16'hA5A5; exp_mem[5] = 16'hA5A5;

        tick();
        tick();
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        tick();

        // load from 0x0040, held through completion
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        repeat (L + 2) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("rd_stall_cycles", 32'(win_stall - s_stall), 32'd3);
        chk("rd_strobe_cycles", 32'(win_rd - s_rd), 32'd2);
        chk("rd_done_pulses", 32'(win_done - s_done), 32'd1);
        chk("rd_rdata", 32'(rdata), 32'h0000BEEF);

        // store 0x1234 to 0x0010
        snap();
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234);
        repeat (L + 2) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("wr_strobe_cycles", 32'(win_wr - s_wr), 32'd2);
        chk("wr_no_read", 32'(win_rd - s_rd), 32'd0);
        chk("wr_rdata_kept", 32'(rdata), 32'h0000BEEF);
        chk("wr_m_addr", 32'(m_addr), 32'h00000010);
        chk("wr_m_wdata", 32'(m_wdata), 32'h00001234);

        // flushed load is ignored, then proceeds once flush drops
        snap();
        drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
        repeat (2) tick();
        chk("flush_stall", 32'(win_stall - s_stall), 32'd0);
        chk("flush_strobe", 32'(win_rd - s_rd), 32'd0);
        chk("flush_rdata", 32'(rdata), 32'h0000BEEF);
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        repeat (L + 2) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("unflush_stall", 32'(win_stall - s_stall), 32'd3);
        chk("unflush_rdata", 32'(rdata), 32'h00001234);

        // back-to-back load then store, inputs held through each completion
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0);
        repeat (L + 2) tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h5555);
        repeat (L + 2) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("b2b_done_pulses", 32'(win_done - s_done), 32'd2);
        chk("b2b_rd_cycles", 32'(win_rd - s_rd), 32'd2);
        chk("b2b_wr_cycles", 32'(win_wr - s_wr), 32'd2);
        chk("b2b_rdata", 32'(rdata), 32'h0000A5A5);

        // async reset while the load is in flight
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("pre_reset_m_read", 32'(m_read), 32'h1);
        #2 reset = 1'b1;
        #1 chk("async_m_read_drop", 32'(m_read), 32'h0);
        tick();
        #2 reset = 1'b0;
        repeat (2) tick();
        chk("abort_no_done", 32'(win_done - s_done), 32'd0);
        chk("abort_rdata_cleared", 32'(rdata), 32'h0);
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        repeat (L + 2) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("post_reset_done", 32'(win_done - s_done), 32'd1);
        chk("post_reset_rdata", 32'(rdata), 32'h00001234);

`ifdef MEM_WRITE_POST_EN
        // posted store followed at once by a load of the same word
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h7777);
        tick();
        chk("post_accept_stall", 32'(last_stall), 32'h0);
        chk("post_accept_done", 32'(last_done), 32'h1);
        snap();
        drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        repeat (2 * L + 3) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("post_rd_stall_cycles", 32'(win_stall - s_stall), 32'd6);
        chk("post_rd_done_pulses", 32'(win_done - s_done), 32'd1);
        chk("post_rd_rdata", 32'(rdata), 32'h00007777);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
